lsu: RTL
========

LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter TIMEOUT, default 255, maximum REQ-state cycles to wait for bus_ready before declaring a bus error; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 mem_read  input  mem_read_t  load kind from the control decoder (NONE/BYTE/HALF/WORD/BYTE_U/HALF_U).
REQ-005 mem_write  input  mem_write_t  store kind from the control decoder (NONE/BYTE/HALF/WORD).
REQ-006 addr  input  32  byte address (ALU result).
REQ-007 wdata  input  32  store data (rs2).
REQ-008 rdata  output  32  extended load result.
REQ-009 stall  output  1  core must hold PC and register-file writes.
REQ-010 misalign  output  1  current request is misaligned.
REQ-011 bus_err  output  1  access timed out.
REQ-012 bus_req  output  1  bus request.
REQ-013 bus_we  output  1  write request.
REQ-014 bus_addr  output  32  word-aligned address, {addr[31:2],2'b00}.
REQ-015 bus_wstrb  output  4  byte-lane write enables.
REQ-016 bus_wdata  output  32  lane-replicated store data.
REQ-017 bus_ready  input  1  bus completes the access this cycle.
REQ-018 bus_rdata  input  32  read word, valid when bus_ready=1.

Function
REQ-019 An op is active when mem_read!=NONE or mem_write!=NONE; if both are non-NONE, the write is performed and the read is ignored.
REQ-020 Alignment: HALF/HALF_U need addr[0]=0; WORD needs addr[1:0]=0; BYTE is always aligned.
REQ-021 Misaligned op: misalign=1 combinationally in IDLE, no bus access, stall=0, rdata=0, FSM stays in IDLE.
REQ-022 FSM states IDLE, REQ, DONE.
REQ-023 IDLE: on an aligned active op, stall=1 and at the next edge register addr, we, size/sign, strobes and wdata, then go to REQ.
REQ-024 REQ: stall=1, bus_req=1; all bus outputs come from registers and stay stable until the exit; input changes are ignored; a cycle counter increments each cycle.
REQ-025 REQ exit: bus_ready=1 at an edge captures bus_rdata and moves to DONE with err=0; otherwise, when the counter reaches TIMEOUT, move to DONE with err=1 and captured data=0.
REQ-026 DONE: stall=0, rdata valid (0 for stores), bus_err=err; unconditionally return to IDLE at the next edge.
REQ-027 Minimum latency: ready in the first REQ cycle gives stall for 2 cycles, with the result in the 3rd cycle; a timeout gives stall for 1+TIMEOUT cycles.
REQ-028 Strobes: BYTE = 4'b0001<<addr[1:0]; HALF = 4'b0011<<addr[1:0]; WORD = 4'b1111; 4'b0000 for loads.
REQ-029 bus_wdata: BYTE {4{wdata[7:0]}}, HALF {2{wdata[15:0]}}, WORD wdata.
REQ-030 Loads select the lane by addr[1:0]: BYTE/HALF sign-extend, BYTE_U/HALF_U zero-extend, WORD pass through.
REQ-031 Outside REQ: bus_req=0 and bus_we=0. Outside DONE: rdata=0 and bus_err=0.

Reset
REQ-032 rst_n=0 immediately forces state IDLE, counter 0, all registers 0, bus_req=0 and stall=0, independent of clk.
REQ-033 A reset during REQ drops bus_req without completing the access; the access is not replayed after reset is released.

Structure
REQ-034 lsu_state_t is defined in typepkg; mem_read_t and mem_write_t are reused from typepkg; TIMEOUT stays a module parameter.
REQ-035 Load lane selection and extension are a combinational sub-module, lsu_lane; strobe and replication logic stay inline.

Verification
REQ-036 LW, addr=0x104, bus_ready in the 1st REQ cycle, bus_rdata=0xDEADBEEF -> stall for 2 cycles, then rdata=0xDEADBEEF.
REQ-037 LB, addr=0x103, bus_rdata=0x80FF0000 -> rdata=0xFFFFFF80; LBU at the same address -> rdata=0x00000080.
REQ-038 SH, addr=0x22, wdata=0x1234ABCD -> bus_addr=0x20, bus_wstrb=4'b1100, bus_wdata=0xABCDABCD, bus_we=1.
REQ-039 LW, addr=0x102 -> misalign=1, stall=0, bus_req never asserted.
REQ-040 TIMEOUT=4, SW with bus_ready held 0 -> bus_req high 4 cycles, DONE with bus_err=1, rdata=0, FSM back to IDLE.
REQ-041 rst_n pulsed low in the 2nd REQ cycle -> bus_req=0 and stall=0 asynchronously; state IDLE after release.

Source files
------------

// File: rtl/typepkg.sv
// Shared types for the load/store unit: decoder access kinds and LSU FSM states.
package typepkg;

    typedef enum logic [2:0] {
        RD_NONE   = 3'd0,
        RD_BYTE   = 3'd1,
        RD_HALF   = 3'd2,
        RD_WORD   = 3'd3,
        RD_BYTE_U = 3'd4,
        RD_HALF_U = 3'd5
    } mem_read_t;

    typedef enum logic [1:0] {
        WR_NONE = 2'd0,
        WR_BYTE = 2'd1,
        WR_HALF = 2'd2,
        WR_WORD = 2'd3
    } mem_write_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_t;

endpackage

// File: rtl/lsu_lane.sv
// Load lane selection: picks the addressed byte/half of a bus word and extends it.
module lsu_lane
    import typepkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  mem_read_t   kind,
    output logic [31:0] data
);

    logic [31:0] shifted;

    // Shift the addressed lane down to bit 0, then sign- or zero-extend by kind
    always_comb begin
        shifted = word >> {offset, 3'b000};
        data    = '0;
        case (kind)
            RD_BYTE:   data = {{24{shifted[7]}}, shifted[7:0]};
            RD_BYTE_U: data = {24'b0, shifted[7:0]};
            RD_HALF:   data = {{16{shifted[15]}}, shifted[15:0]};
            RD_HALF_U: data = {16'b0, shifted[15:0]};
            RD_WORD:   data = word;
            default:   data = '0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one bus access per op via IDLE -> REQ -> DONE, with timeout.
module lsu
    import typepkg::*;
#(
    parameter int unsigned TIMEOUT = 255
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  mem_read_t   mem_read,
    input  mem_write_t  mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        misalign,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    lsu_state_t  state, state_next;
    logic [31:0] addr_q, wdata_q, data_q;
    logic        we_q, err_q;
    mem_read_t   kind_q;
    logic [3:0]  wstrb_q;
    logic [7:0]  cnt;

    logic        is_write, active, aligned, load;
    logic [3:0]  strobe;
    logic [31:0] wdata_rep, lane_data;

    lsu_lane u_lane (
        .word   (bus_rdata),
        .offset (addr_q[1:0]),
        .kind   (kind_q),
        .data   (lane_data)
    );

    // Decode the incoming op: activity, alignment, strobes and lane-replicated data
    always_comb begin
        is_write  = (mem_write != WR_NONE);
        active    = is_write || (mem_read != RD_NONE);
        aligned   = 1'b1;
        strobe    = 4'b0000;
        wdata_rep = '0;
        if (is_write) begin
            case (mem_write)
                WR_BYTE: begin
                    strobe    = 4'b0001 << addr[1:0];
                    wdata_rep = {4{wdata[7:0]}};
                end
                WR_HALF: begin
                    aligned   = ~addr[0];
                    strobe    = 4'b0011 << addr[1:0];
                    wdata_rep = {2{wdata[15:0]}};
                end
                WR_WORD: begin
                    aligned   = (addr[1:0] == 2'b00);
                    strobe    = 4'b1111;
                    wdata_rep = wdata;
                end
                default: ;
            endcase
        end else begin
            case (mem_read)
                RD_HALF, RD_HALF_U: aligned = ~addr[0];
                RD_WORD:            aligned = (addr[1:0] == 2'b00);
                default:            aligned = 1'b1;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next-state and per-state outputs
    always_comb begin
        state_next = state;
        load       = 1'b0;
        stall      = 1'b0;
        misalign   = 1'b0;
        bus_req    = 1'b0;
        bus_we     = 1'b0;
        rdata      = '0;
        bus_err    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (active) begin
                    if (aligned) begin
                        stall      = 1'b1;
                        load       = 1'b1;
                        state_next = ST_REQ;
                    end else begin
                        misalign = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                stall   = 1'b1;
                bus_req = 1'b1;
                bus_we  = we_q;
                if (bus_ready || (cnt == CNT_LAST)) state_next = ST_DONE;
            end
            ST_DONE: begin
                rdata      = data_q;
                bus_err    = err_q;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Access registers: captured on entry to REQ, result/error captured on REQ exit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            kind_q  <= RD_NONE;
            wstrb_q <= '0;
            cnt     <= '0;
        end else if (load) begin
            addr_q  <= addr;
            wdata_q <= wdata_rep;
            data_q  <= '0;
            we_q    <= is_write;
            err_q   <= 1'b0;
            kind_q  <= is_write ? RD_NONE : mem_read;
            wstrb_q <= strobe;
            cnt     <= '0;
        end else if (state == ST_REQ) begin
            cnt <= cnt + 8'd1;
            if (bus_ready) begin
                data_q <= we_q ? '0 : lane_data;
                err_q  <= 1'b0;
            end else if (cnt == CNT_LAST) begin
                data_q <= '0;
                err_q  <= 1'b1;
            end
        end
    end

    assign bus_addr  = {addr_q[31:2], 2'b00};
    assign bus_wstrb = wstrb_q;
    assign bus_wdata = wdata_q;

endmodule
